// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ack handshake and
// presents {if_pc, if_instr, if_valid} to IF/ID, applying EX-resolved redirects.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [2:0]  npc_op,
   input  logic        br_taken,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_rs1,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        flush,
   output logic        misalign
);

   typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] drop_target;
   logic [31:0] skid_pc;
   logic [31:0] skid_instr;

   logic        redirect;
   logic        slot_free;
   logic [31:0] raw_target;
   logic [31:0] target;

   // jalr takes priority over jal/branch; jal and branch share the pc-relative form.
   always_comb begin
      redirect   = ex_valid & (npc_op[2] | npc_op[1] | (npc_op[0] & br_taken));
      raw_target = npc_op[2] ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
      target     = {raw_target[31:2], 2'b00};
      slot_free  = !if_valid || !stall;
   end

   assign flush     = redirect & rstn;
   assign imem_req  = (state == REQ) || (state == DROP);
   assign imem_addr = pc;

   // NOTE: every register here uses non-blocking assignment; where one is written
   // twice in the same edge (if_valid), the later statement wins, which is how
   // redirect is made to override every slot update above it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         drop_target <= RESET_PC;
         skid_pc     <= '0;
         skid_instr  <= '0;
         if_valid    <= 1'b0;
         if_pc       <= '0;
         if_instr    <= '0;
         misalign    <= 1'b0;
      end else begin
         misalign <= redirect & raw_target[1];

         // Slot empties once consumed; a stalled live slot holds its contents.
         if (slot_free)
            if_valid <= 1'b0;

         unique case (state)
            IDLE: begin
               state <= REQ;
               if (redirect)
                  pc <= target;
            end
            REQ: begin
               if (redirect) begin
                  if (imem_ack) begin
                     pc <= target;
                  end else begin
                     drop_target <= target;
                     state       <= DROP;
                  end
               end else if (imem_ack) begin
                  pc <= pc + 32'd4;
                  if (slot_free) begin
                     if_valid <= 1'b1;
                     if_pc    <= pc;
                     if_instr <= imem_rdata;
                  end else begin
                     skid_pc    <= pc;
                     skid_instr <= imem_rdata;
                     state      <= HOLD;
                  end
               end
            end
            // The old request must complete before the redirect target can be fetched.
            DROP: begin
               if (imem_ack) begin
                  pc    <= redirect ? target : drop_target;
                  state <= REQ;
               end else if (redirect) begin
                  drop_target <= target;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc    <= target;
                  state <= REQ;
               end else if (!stall) begin
                  if_valid <= 1'b1;
                  if_pc    <= skid_pc;
                  if_instr <= skid_instr;
                  state    <= REQ;
               end
            end
            default: state <= IDLE;
         endcase

         if (redirect)
            if_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized run
// scored against a program-order model of the delivered instruction stream.
module tb_pc_fetch_unit;

   logic        clk;
   logic        rstn;
   logic [2:0]  npc_op;
   logic        br_taken;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic [31:0] ex_rs1;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        flush;
   logic        misalign;

   int vectors;
   int miscompares;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .npc_op     (npc_op),
      .br_taken   (br_taken),
      .ex_valid   (ex_valid),
      .ex_pc      (ex_pc),
      .ex_imm     (ex_imm),
      .ex_rs1     (ex_rs1),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .flush      (flush),
      .misalign   (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      npc_op = 3'b000; br_taken = 1'b0; ex_valid = 1'b0;
      ex_pc = '0; ex_imm = '0; ex_rs1 = '0; stall = 1'b0;
      imem_ack = 1'b0; imem_rdata = '0;
   endtask

   task automatic drive_mem(input logic ack);
      imem_ack   = ack;
      imem_rdata = mem_f(imem_addr);
   endtask

   task automatic do_reset();
      idle_inputs();
      rstn = 1'b0;
      cyc();
      cyc();
      rstn = 1'b1;
   endtask

   task automatic start();
      do_reset();
      cyc();
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 1'b0;
      ex_valid = 1'b1; npc_op = 3'b010;
      cyc();
      #1;
      vectors++;
      if (flush !== 1'b0) begin miscompares++; $display("FAIL rst_flush got %b exp 0", flush); end
      vectors++;
      if ({imem_req, if_valid, misalign} !== 3'b000) begin
         miscompares++; $display("FAIL rst_ctrl got req/valid/mis %b exp 000", {imem_req, if_valid, misalign});
      end
      vectors++;
      if (if_pc !== 32'h0 || if_instr !== 32'h0 || imem_addr !== 32'h0) begin
         miscompares++; $display("FAIL rst_data got pc %h instr %h addr %h exp 0", if_pc, if_instr, imem_addr);
      end
      idle_inputs();
      cyc();
      rstn = 1'b1;
      #1;
      vectors++;
      if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_idle got req %b exp 0", imem_req); end
      cyc();
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         miscompares++; $display("FAIL rst_first_req got req %b addr %h exp 1 0", imem_req, imem_addr);
      end
   endtask

   task automatic test_back_to_back();
      start();
      for (int i = 0; i < 4; i++) begin
         drive_mem(1'b1);
         vectors++;
         if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
            miscompares++; $display("FAIL b2b_addr%0d got %h exp %h", i, imem_addr, 32'(4 * i));
         end
         vectors++;
         if (i == 0 && if_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_first_valid got %b exp 0", if_valid);
         end else if (i > 0 && (if_valid !== 1'b1 || if_pc !== 32'(4 * (i - 1)) || if_instr !== mem_f(32'(4 * (i - 1))))) begin
            miscompares++; $display("FAIL b2b_if%0d got v %b pc %h exp 1 %h", i, if_valid, if_pc, 32'(4 * (i - 1)));
         end
         cyc();
      end
   endtask

   task automatic test_jal();
      start();
      for (int i = 0; i < 4; i++) begin drive_mem(1'b1); cyc(); end
      drive_mem(1'b1);
      ex_valid = 1'b1; npc_op = 3'b010; ex_pc = 32'h10; ex_imm = 32'h20;
      #1;
      vectors++;
      if (flush !== 1'b1) begin miscompares++; $display("FAIL jal_flush got %b exp 1", flush); end
      cyc();
      idle_inputs();
      vectors++;
      if (if_valid !== 1'b0 || imem_addr !== 32'h30) begin
         miscompares++; $display("FAIL jal_after got v %b addr %h exp 0 30", if_valid, imem_addr);
      end
      drive_mem(1'b1);
      cyc();
      vectors++;
      if (if_valid !== 1'b1 || if_pc !== 32'h30 || if_instr !== mem_f(32'h30)) begin
         miscompares++; $display("FAIL jal_target_fetch got v %b pc %h exp 1 30", if_valid, if_pc);
      end
   endtask

   task automatic test_jalr_misalign();
      start();
      drive_mem(1'b0);
      ex_valid = 1'b1; npc_op = 3'b100; ex_rs1 = 32'h101; ex_imm = 32'h4;
      cyc();
      idle_inputs();
      vectors++;
      if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         miscompares++; $display("FAIL jalr_drop got mis %b req %b addr %h exp 0 1 0", misalign, imem_req, imem_addr);
      end
      drive_mem(1'b1);
      cyc();
      vectors++;
      if (imem_addr !== 32'h104 || if_valid !== 1'b0) begin
         miscompares++; $display("FAIL jalr_target got addr %h v %b exp 104 0", imem_addr, if_valid);
      end
      drive_mem(1'b1);
      ex_valid = 1'b1; npc_op = 3'b100; ex_rs1 = 32'h102; ex_imm = 32'h0;
      cyc();
      idle_inputs();
      vectors++;
      if (misalign !== 1'b1 || imem_addr !== 32'h100) begin
         miscompares++; $display("FAIL jalr_misalign got mis %b addr %h exp 1 100", misalign, imem_addr);
      end
      cyc();
      vectors++;
      if (misalign !== 1'b0) begin miscompares++; $display("FAIL jalr_mis_pulse got %b exp 0", misalign); end
   endtask

   task automatic test_redirect_outstanding();
      start();
      for (int i = 0; i < 16; i++) begin drive_mem(1'b1); cyc(); end
      drive_mem(1'b0);
      ex_valid = 1'b1; npc_op = 3'b010; ex_pc = 32'h100; ex_imm = 32'h100;
      cyc();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_valid !== 1'b0) begin
            miscompares++; $display("FAIL drop_hold%0d got req %b addr %h v %b exp 1 40 0", i, imem_req, imem_addr, if_valid);
         end
         drive_mem(i == 2);
         cyc();
      end
      imem_ack = 1'b0;
      vectors++;
      if (imem_addr !== 32'h200 || if_valid !== 1'b0) begin
         miscompares++; $display("FAIL drop_done got addr %h v %b exp 200 0", imem_addr, if_valid);
      end
   endtask

   task automatic test_stall_skid();
      start();
      drive_mem(1'b1);
      cyc();
      stall = 1'b1;
      drive_mem(1'b1);
      cyc();
      for (int i = 0; i < 2; i++) begin
         drive_mem(1'b0);
         vectors++;
         if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_f(32'h0) || imem_req !== 1'b0) begin
            miscompares++; $display("FAIL skid_frozen%0d got v %b pc %h req %b exp 1 0 0", i, if_valid, if_pc, imem_req);
         end
         cyc();
      end
      stall = 1'b0;
      cyc();
      vectors++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== mem_f(32'h4)) begin
         miscompares++; $display("FAIL skid_present got v %b pc %h exp 1 4", if_valid, if_pc);
      end
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
         miscompares++; $display("FAIL skid_resume got req %b addr %h exp 1 8", imem_req, imem_addr);
      end
   endtask

   task automatic test_branch();
      start();
      drive_mem(1'b1);
      ex_valid = 1'b1; npc_op = 3'b001; br_taken = 1'b0; ex_pc = 32'h80; ex_imm = 32'h40;
      #1;
      vectors++;
      if (flush !== 1'b0) begin miscompares++; $display("FAIL br_nt_flush got %b exp 0", flush); end
      cyc();
      vectors++;
      if (imem_addr !== 32'h4 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
         miscompares++; $display("FAIL br_nt_seq got addr %h v %b pc %h exp 4 1 0", imem_addr, if_valid, if_pc);
      end
      drive_mem(1'b1);
      br_taken = 1'b1;
      #1;
      vectors++;
      if (flush !== 1'b1) begin miscompares++; $display("FAIL br_t_flush got %b exp 1", flush); end
      cyc();
      idle_inputs();
      vectors++;
      if (imem_addr !== 32'hC0 || if_valid !== 1'b0) begin
         miscompares++; $display("FAIL br_t_target got addr %h v %b exp c0 0", imem_addr, if_valid);
      end
   endtask

   task automatic test_async_reset();
      start();
      for (int i = 0; i < 2; i++) begin drive_mem(1'b1); cyc(); end
      drive_mem(1'b1);
      #2 rstn = 1'b0;
      #1;
      vectors++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || imem_addr !== 32'h0) begin
         miscompares++; $display("FAIL arst_now got req %b v %b pc %h addr %h exp 0 0 0 0", imem_req, if_valid, if_pc, imem_addr);
      end
      cyc();
      rstn = 1'b1;
      imem_ack = 1'b1;
      cyc();
      imem_ack = 1'b0;
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
         miscompares++; $display("FAIL arst_ignore got req %b addr %h v %b exp 1 0 0", imem_req, imem_addr, if_valid);
      end
   endtask

   // Program-order model: every instruction consumed by IF/ID must be the next
   // sequential address since reset or the most recent redirect target.
   task automatic test_random();
      logic [31:0] exp_pc, tgt, prev_addr;
      logic        exp_mis, prev_req, prev_ack, redir;
      int          consumed;
      start();
      exp_pc = 32'h0; exp_mis = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
      consumed = 0;
      for (int c = 0; c < 3000; c++) begin
         if (prev_req && !prev_ack) begin
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
               miscompares++; $display("FAIL rnd_hold c%0d got req %b addr %h exp 1 %h", c, imem_req, imem_addr, prev_addr);
            end
         end
         vectors++;
         if (misalign !== exp_mis) begin
            miscompares++; $display("FAIL rnd_misalign c%0d got %b exp %b", c, misalign, exp_mis);
         end
         stall    = ($urandom_range(0, 9) < 3);
         drive_mem(imem_req && ($urandom_range(0, 1) == 1));
         ex_valid = ($urandom_range(0, 15) < 2);
         npc_op   = 3'($urandom_range(0, 7));
         br_taken = 1'($urandom);
         ex_pc    = $urandom & ~32'h3;
         ex_imm   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
         ex_rs1   = $urandom;
         #1;
         redir = ex_valid && (npc_op[2] || npc_op[1] || (npc_op[0] && br_taken));
         tgt   = npc_op[2] ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
         vectors++;
         if (flush !== redir) begin
            miscompares++; $display("FAIL rnd_flush c%0d got %b exp %b", c, flush, redir);
         end
         if (if_valid && !stall && !redir) begin
            vectors++;
            if (if_pc !== exp_pc || if_instr !== mem_f(exp_pc)) begin
               miscompares++; $display("FAIL rnd_stream c%0d got pc %h instr %h exp %h %h", c, if_pc, if_instr, exp_pc, mem_f(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         exp_mis = redir && tgt[1];
         if (redir)
            exp_pc = {tgt[31:2], 2'b00};
         prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
         cyc();
      end
      idle_inputs();
      vectors++;
      if (consumed < 200) begin
         miscompares++; $display("FAIL rnd_progress got %0d consumed exp >= 200", consumed);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rstn = 1'b0;
      idle_inputs();
      test_reset();
      test_back_to_back();
      test_jal();
      test_jalr_misalign();
      test_redirect_outstanding();
      test_stall_skid();
      test_branch();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
